// File: rtl/game_pkg.sv
// Shared game constants and the collision controller state encoding.
package game_pkg;

    localparam int unsigned LIVES_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned DEFAULT_INITIAL_LIVES = 3;
    localparam int unsigned DEFAULT_INVULN_FRAMES = 60;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        OVER = 2'd2
    } gameState_t;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter that steps once per startOfFrame, holds while paused and stops at zero.
module frame_down_counter
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             load,
    input  logic             clear,
    input  logic             hold,
    input  logic [CNT_W-1:0] loadValue,
    output logic [CNT_W-1:0] count
);

    // clear beats load, load beats a same-cycle frame step
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (startOfFrame && !hold && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/towers_collision_ctrl.sv
// Player/tower collision controller: hit acceptance, lives, post-hit grace window, game over.
// Optional build macro COLLISION_BLINK_EN adds player blink during the grace window.
module towers_collision_ctrl
    import game_pkg::*;
#(
    parameter int unsigned INITIAL_LIVES = DEFAULT_INITIAL_LIVES,
    parameter int unsigned INVULN_FRAMES = DEFAULT_INVULN_FRAMES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               playerDR,
    input  logic               towersDR,
    input  logic               pauseReq,
    input  logic               restart,
    output logic               collision,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               gameOver,
    output logic               pause,
    output logic               blink
);

    gameState_t         state;
    gameState_t         stateNext;
    logic [LIVES_W-1:0] livesNext;
    logic               overlapReg;
    logic               hitSeen;
    logic               hitAccept;
    logic               cntLoad;
    logic [CNT_W-1:0]   invulnCnt;

    // pixel overlap is registered before it can count as a hit
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overlapReg <= 1'b0;
        end else begin
            overlapReg <= playerDR & towersDR;
        end
    end

    // one accepted hit per frame; an overlap on the frame-start cycle still marks the new frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitSeen <= 1'b0;
        end else if (restart) begin
            hitSeen <= 1'b0;
        end else if (overlapReg) begin
            hitSeen <= 1'b1;
        end else if (startOfFrame) begin
            hitSeen <= 1'b0;
        end
    end

    frame_down_counter uInvulnCnt (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .load         (cntLoad),
        .clear        (restart),
        .hold         (pauseReq),
        .loadValue    (CNT_W'(INVULN_FRAMES)),
        .count        (invulnCnt)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= PLAY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        livesNext = lives;
        hitAccept = 1'b0;
        cntLoad   = 1'b0;
        if (restart) begin
            stateNext = PLAY;
            livesNext = LIVES_W'(INITIAL_LIVES);
        end else begin
            case (state)
                PLAY: begin
                    if (overlapReg && !hitSeen) begin
                        hitAccept = 1'b1;
                        if (lives <= LIVES_W'(1)) begin
                            stateNext = OVER;
                            livesNext = '0;
                        end else begin
                            stateNext = HIT;
                            livesNext = lives - LIVES_W'(1);
                            cntLoad   = 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (startOfFrame && !pauseReq && (invulnCnt <= CNT_W'(1))) begin
                        stateNext = PLAY;
                    end
                end
                OVER: begin
                    livesNext = '0;
                end
                default: begin
                    stateNext = PLAY;
                end
            endcase
        end
    end

    // outputs follow the next state so they line up with the collision pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lives        <= LIVES_W'(INITIAL_LIVES);
            collision    <= 1'b0;
            invulnerable <= 1'b0;
            gameOver     <= 1'b0;
            pause        <= 1'b0;
        end else begin
            lives        <= livesNext;
            collision    <= hitAccept;
            invulnerable <= (stateNext == HIT);
            gameOver     <= (stateNext == OVER);
            pause        <= pauseReq | (stateNext == OVER);
        end
    end

`ifdef COLLISION_BLINK_EN
    logic [3:0] frameCnt;

    // frame counter runs only inside the grace window; bit 3 gives an 8-frame blink phase
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frameCnt <= '0;
            blink    <= 1'b0;
        end else begin
            if (stateNext != HIT) begin
                frameCnt <= '0;
            end else if (startOfFrame) begin
                frameCnt <= frameCnt + 4'd1;
            end
            blink <= (stateNext == HIT) & frameCnt[3];
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_towers_collision_ctrl.sv
// Self-checking bench for towers_collision_ctrl against a rule-level game model.
module tb_towers_collision_ctrl;
    import game_pkg::*;

    localparam int INIT      = int'(DEFAULT_INITIAL_LIVES);
    localparam int INV       = int'(DEFAULT_INVULN_FRAMES);
    localparam int FRAME_LEN = 16;
    localparam int M_PLAY    = 0;
    localparam int M_HIT     = 1;
    localparam int M_OVER    = 2;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       playerDR;
    logic       towersDR;
    logic       pauseReq;
    logic       restart;
    logic       collision;
    logic [3:0] lives;
    logic       invulnerable;
    logic       gameOver;
    logic       pause;
    logic       blink;

    int checks = 0;
    int errors = 0;

    // game model
    int mMode;
    int mLives;
    int mInvLeft;
    bit mSeen;
    bit mOvl;
    bit mColl;
    int collCount = 0;

    towers_collision_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .playerDR     (playerDR),
        .towersDR     (towersDR),
        .pauseReq     (pauseReq),
        .restart      (restart),
        .collision    (collision),
        .lives        (lives),
        .invulnerable (invulnerable),
        .gameOver     (gameOver),
        .pause        (pause),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("collision",    8'(collision),    8'(mColl));
        check("lives",        8'(lives),        8'(mLives));
        check("invulnerable", 8'(invulnerable), 8'(mMode == M_HIT));
        check("gameOver",     8'(gameOver),     8'(mMode == M_OVER));
        check("pause",        8'(pause),        8'(pauseReq | (mMode == M_OVER)));
        check("blink",        8'(blink),        8'(0));
    endtask

    task automatic modelReset();
        mMode    = M_PLAY;
        mLives   = INIT;
        mInvLeft = 0;
        mSeen    = 1'b0;
        mOvl     = 1'b0;
        mColl    = 1'b0;
    endtask

    // one clock of game rules; mOvl is the overlap seen on the previous pixel
    task automatic modelUpdate(input bit sof, input bit ov, input bit pz, input bit rs);
        bit acc;
        acc = (mMode == M_PLAY) && !mSeen && mOvl && !rs;
        if (rs) begin
            mMode    = M_PLAY;
            mLives   = INIT;
            mInvLeft = 0;
            mSeen    = 1'b0;
            mColl    = 1'b0;
        end else begin
            mColl = acc;
            if (acc) begin
                if (mLives == 1) begin
                    mMode  = M_OVER;
                    mLives = 0;
                end else begin
                    mMode    = M_HIT;
                    mLives   = mLives - 1;
                    mInvLeft = INV;
                end
            end else if (mMode == M_HIT && sof && !pz) begin
                mInvLeft = mInvLeft - 1;
                if (mInvLeft == 0) mMode = M_PLAY;
            end
            if (mOvl) mSeen = 1'b1;
            else if (sof) mSeen = 1'b0;
        end
        mOvl = ov;
    endtask

    task automatic step(input bit sof, input bit p, input bit t, input bit pz, input bit rs);
        @(negedge clk);
        startOfFrame = sof;
        playerDR     = p;
        towersDR     = t;
        pauseReq     = pz;
        restart      = rs;
        @(posedge clk);
        modelUpdate(sof, p & t, pz, rs);
        #1;
        checkAll();
        if (collision === 1'b1) collCount++;
    endtask

    // a frame of FRAME_LEN pixels; mask marks overlapping pixels, others may light the player alone
    task automatic runFrame(input logic [15:0] mask, input bit pz, input int rsAt);
        for (int i = 0; i < FRAME_LEN; i++) begin
            step(i == 0, mask[i] | 1'($urandom_range(0, 1)), mask[i], pz, i == rsAt);
        end
    endtask

    initial begin
        int c0;
        int f;
        logic [15:0] m;

        resetN = 1'b0;
        startOfFrame = 1'b0;
        playerDR = 1'b0;
        towersDR = 1'b0;
        pauseReq = 1'b0;
        restart = 1'b0;
        modelReset();
        #12;
        checkAll();
        check("resetLives", 8'(lives), 8'(INIT));
        @(negedge clk);
        resetN = 1'b1;

        // single overlapping pixel in play
        runFrame(16'h0000, 1'b0, -1);
        c0 = collCount;
        runFrame(16'h0020, 1'b0, -1);
        check("singleHitPulses", 8'(collCount - c0), 8'(1));
        check("singleHitLives",  8'(lives), 8'(2));
        check("singleHitInvuln", 8'(invulnerable), 8'(1));

        // overlaps every frame of the grace window are ignored
        c0 = collCount;
        for (int i = 0; i < INV - 1; i++) begin
            m = 16'($urandom) | 16'h0100;
            runFrame(m, 1'b0, -1);
        end
        check("graceStillInvuln", 8'(invulnerable), 8'(1));
        runFrame(16'h0000, 1'b0, -1);
        check("graceEndsInvuln", 8'(invulnerable), 8'(0));
        check("gracePulses",     8'(collCount - c0), 8'(0));
        check("graceLives",      8'(lives), 8'(2));

        // five overlap pixels in one frame count once
        c0 = collCount;
        runFrame(16'h0AA8, 1'b0, -1);
        check("multiPixelPulses", 8'(collCount - c0), 8'(1));
        check("multiPixelLives",  8'(lives), 8'(1));

        // grace window with random pause frames freezing the countdown
        f = 0;
        while (mMode == M_HIT && f < 300) begin
            m = (mInvLeft <= 1) ? 16'h0000 : 16'($urandom);
            runFrame(m, $urandom_range(0, 2) == 0, -1);
            f++;
        end
        check("pausedGraceEnds", 8'(mMode), 8'(M_PLAY));
        check("pausedGraceFrames", 8'(f >= INV), 8'(1));

        // hit while paused on the last life ends the game
        c0 = collCount;
        runFrame(16'h0010, 1'b1, -1);
        check("lastHitPulses", 8'(collCount - c0), 8'(1));
        check("lastHitLives",  8'(lives), 8'(0));
        check("lastHitOver",   8'(gameOver), 8'(1));
        check("lastHitPause",  8'(pause), 8'(1));
        c0 = collCount;
        for (int i = 0; i < 3; i++) runFrame(16'h0F0F, 1'b0, -1);
        check("overPulses", 8'(collCount - c0), 8'(0));
        check("overPause",  8'(pause), 8'(1));

        // restart from game over, then restart racing a registered overlap
        runFrame(16'h0000, 1'b0, 4);
        check("restartLives", 8'(lives), 8'(INIT));
        check("restartOver",  8'(gameOver), 8'(0));
        c0 = collCount;
        runFrame(16'h0040, 1'b0, 7);
        check("raceNoPulse", 8'(collCount - c0), 8'(0));
        check("raceLives",   8'(lives), 8'(INIT));
        check("raceInvuln",  8'(invulnerable), 8'(0));
        runFrame(16'h0004, 1'b0, -1);
        check("postRaceHit", 8'(lives), 8'(INIT - 1));

        // asynchronous reset in the middle of the grace window
        for (int i = 0; i < 3; i++) runFrame(16'($urandom), 1'b0, -1);
        check("preResetInvuln", 8'(invulnerable), 8'(1));
        @(negedge clk);
        startOfFrame = 1'b0;
        playerDR = 1'b0;
        towersDR = 1'b0;
        pauseReq = 1'b0;
        restart = 1'b0;
        @(posedge clk);
        modelUpdate(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        resetN = 1'b0;
        #1;
        modelReset();
        checkAll();
        check("asyncResetLives", 8'(lives), 8'(INIT));
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // random play with pauses and occasional restarts
        for (int i = 0; i < 60; i++) begin
            m = 16'($urandom) & 16'($urandom) & 16'($urandom);
            runFrame(m, $urandom_range(0, 3) == 0,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
